// File: rtl/da_fir_serial_core_if.sv
// ---------------------------------------------------------------------------
// da_fir_serial_core_if
// Bundles the three buses around the bit-serial DA FIR core:
//   - sample input stream : in_data / in_valid / in_ready
//   - DA LUT lookup       : lut_addr (core -> LUT), lut_data (LUT -> core)
//   - result stream       : out_data / out_valid / out_ready
//   - clr                 : synchronous delay-line clear (IDLE only)
// Modports:
//   slave  - the core side (consumes samples, produces results)
//   master - the environment side (sample source, LUT, result sink)
// ---------------------------------------------------------------------------
interface da_fir_serial_core_if #(
    parameter int DATA_W = 8,
    parameter int LUT_W  = 17,
    parameter int OUT_W  = DATA_W + LUT_W
);
    logic                     clr;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic        [6:0]        lut_addr;
    logic signed [LUT_W-1:0]  lut_data;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  clr, in_data, in_valid, lut_data, out_ready,
        output in_ready, lut_addr, out_data, out_valid
    );

    modport master (
        output clr, in_data, in_valid, lut_data, out_ready,
        input  in_ready, lut_addr, out_data, out_valid
    );
endinterface

// File: rtl/da_fir_serial_core.sv
// ---------------------------------------------------------------------------
// da_fir_serial_core
// Bit-serial distributed-arithmetic engine for a 7-tap symmetric FIR.
// Each accepted sample is shifted into a 7-deep delay line, then the taps
// are walked MSB first for DATA_W cycles. Every cycle the 7 current tap bits
// form the address of an external combinational LUT whose signed partial sum
// is shift-accumulated; the sign-bit slice is subtracted (two's complement
// weight). The full-precision result is then held until the sink takes it.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - slave side of da_fir_serial_core_if
//            (clr, in_* sample stream, lut_addr/lut_data, out_* result stream)
// ---------------------------------------------------------------------------
module da_fir_serial_core #(
    parameter int DATA_W = 8,
    parameter int LUT_W  = 17,
    parameter int OUT_W  = DATA_W + LUT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    da_fir_serial_core_if.slave   bus
);
    localparam int NUM_TAPS = 7;
    localparam int CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                               state;
    logic [NUM_TAPS-1:0][DATA_W-1:0]      taps;      // taps[0] = newest sample
    logic [CNT_W-1:0]                     bit_cnt;
    logic signed [OUT_W-1:0]              acc;
    logic signed [OUT_W-1:0]              acc_next;
    logic signed [OUT_W-1:0]              lut_sext;
    logic signed [OUT_W-1:0]              out_data_r;
    logic                                 out_valid_r;
    logic [NUM_TAPS-1:0]                  addr_bits;
    logic                                 in_ready_c;
    logic                                 accept;

    // Bit slice of every tap at the current bit position.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_addr
        assign addr_bits[k] = taps[k][bit_cnt];
    end

    assign bus.lut_addr  = (state == CALC) ? addr_bits : '0;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;

    // clr takes priority over an offered sample.
    assign in_ready_c    = (state == IDLE) && !bus.clr;
    assign bus.in_ready  = in_ready_c;
    assign accept        = bus.in_valid && in_ready_c;

    assign lut_sext = {{(OUT_W-LUT_W){bus.lut_data[LUT_W-1]}}, bus.lut_data};

    // MSB slice carries negative weight; later slices shift-add.
    always_comb begin
        acc_next = '0;
        if (bit_cnt == CNT_MSB)
            acc_next = -lut_sext;
        else
            acc_next = (acc <<< 1) + lut_sext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            taps        <= '0;
            bit_cnt     <= CNT_MSB;
            acc         <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        taps <= '0;
                    end else if (accept) begin
                        taps    <= {taps[NUM_TAPS-2:0], bus.in_data};
                        acc     <= '0;
                        bit_cnt <= CNT_MSB;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (bit_cnt == '0) begin
                        out_data_r  <= acc_next;
                        out_valid_r <= 1'b1;
                        bit_cnt     <= CNT_MSB;
                        state       <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_da_fir_serial_core.sv
// ---------------------------------------------------------------------------
// tb_da_fir_serial_core
// Scoreboard bench: the driver pushes the expected filter output when a
// sample is accepted; an independent monitor pops and compares on every
// out_valid/out_ready transfer. The reference is a plain dot product of the
// coefficient set with the sample history; the LUT is modelled from the
// same coefficients.
// ---------------------------------------------------------------------------
module tb_da_fir_serial_core;
    localparam int DATA_W = 8;
    localparam int LUT_W  = 17;
    localparam int OUT_W  = DATA_W + LUT_W;

    logic clk;
    logic reset;

    da_fir_serial_core_if #(.DATA_W(DATA_W), .LUT_W(LUT_W), .OUT_W(OUT_W)) bus ();

    da_fir_serial_core #(.DATA_W(DATA_W), .LUT_W(LUT_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int coef [7] = '{-1495, -942, 9687, 18269, 9687, -942, -1495};
    int hist [7];
    int exp_q [$];
    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    int ordy_mode = 1;   // 0: out_ready low, 1: high, 2: random

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational DA LUT: sum of coefficients whose tap bit is set.
    always_comb begin
        logic signed [LUT_W-1:0] s;
        s = '0;
        for (int k = 0; k < 7; k++)
            if (bus.lut_addr[k]) s = s + LUT_W'(coef[k]);
        bus.lut_data = s;
    end

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int ref_out();
        int s = 0;
        for (int k = 0; k < 7; k++) s += coef[k] * hist[k];
        return s;
    endfunction

    function automatic void hist_clear();
        for (int k = 0; k < 7; k++) hist[k] = 0;
    endfunction

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ordy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare every transfer against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", longint'(bus.out_data), 0);
                    if (bus.out_data == '0) begin
                        errors++;
                        $display("FAIL unexpected_output: got transfer expected none");
                    end
                end else begin
                    chk("out_data", longint'(bus.out_data), longint'(exp_q.pop_front()));
                end
            end
        end
    end

    // Offer x until accepted; on accept update history and push expectation.
    task automatic send(input int x, input bit use_c = 1'b0, input int c = 0);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = x[DATA_W-1:0];
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            exp_q.push_back(use_c ? c : ref_out());
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready && exp_q.size() == 0) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    int imp_exp  [8] = '{-1495, -942, 9687, 18269, 9687, -942, -1495, 0};
    int step_exp [8] = '{-1495, -2437, 7250, 25519, 35206, 34264, 32769, 32769};

    initial begin
        bit ok;
        bit seen;
        logic signed [OUT_W-1:0] held;
        int base;
        logic [6:0] ea;

        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        hist_clear();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_lut_addr",  bus.lut_addr,  0);

        // Impulse then step.
        foreach (imp_exp[i]) send((i == 0) ? 1 : 0, 1'b1, imp_exp[i]);
        foreach (step_exp[i]) send(1, 1'b1, step_exp[i]);
        wait_idle();

        // Extremes.
        for (int i = 0; i < 7; i++) send(-128, i == 6, -4194432);
        for (int i = 0; i < 7; i++) send(127, i == 6, 4161663);
        wait_idle();

        // Timing and LUT address trace.
        send($urandom_range(0, 255) - 128);
        ok = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            @(negedge clk);
            for (int k = 0; k < 7; k++) ea[k] = hist[k][DATA_W-1-i];
            chk("lut_addr_trace", bus.lut_addr, ea);
            if (bus.in_ready || bus.out_valid) ok = 1'b0;
        end
        chk("calc_busy_no_valid", ok, 1);
        @(negedge clk);
        chk("out_valid_at_T+8", bus.out_valid, 1);
        wait_idle();

        // Backpressure.
        ordy_mode = 0;
        send(-77);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 8'sd9;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin seen = 1'b1; break; end
        end
        chk("bp_out_valid_seen", seen, 1);
        held = bus.out_data;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data != held || bus.in_ready) ok = 1'b0;
        end
        chk("bp_hold_stable", ok, 1);
        base = n_xfer;
        ordy_mode = 1;
        send(9);
        chk("bp_single_transfer", n_xfer, base + 1);
        wait_idle();

        // clr after a step, then zero input.
        for (int i = 0; i < 7; i++) send(1);
        wait_idle();
        @(posedge clk); #1 bus.clr = 1'b1;
        @(posedge clk); #1 bus.clr = 1'b0;
        hist_clear();
        send(0, 1'b1, 0);
        wait_idle();

        // clr together with in_valid: no accept that cycle.
        for (int i = 0; i < 3; i++) send(3);
        wait_idle();
        @(posedge clk); #1;
        bus.clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'sd5;
        @(negedge clk);
        chk("clr_blocks_ready", bus.in_ready, 0);
        @(posedge clk); #1 bus.clr = 1'b0; bus.in_valid = 1'b0;
        hist_clear();
        send(5, 1'b1, -7475);
        wait_idle();

        // Reset in the 4th CALC cycle.
        for (int i = 0; i < 4; i++) send(7);
        wait_idle();
        send(1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        void'(exp_q.pop_back());
        hist_clear();
        @(posedge clk); #1 reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b0;
        end
        chk("reset_no_out_valid", ok, 1);
        chk("reset_in_ready", bus.in_ready, 1);
        send(1, 1'b1, -1495);
        wait_idle();

        // Randomized samples with random backpressure.
        ordy_mode = 2;
        for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 255)) - 128);
        ordy_mode = 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
